// File: rtl/imem_fetch_port.sv
// Clocked, handshaked instruction memory for the fetch stage: configurable
// wait states, program-load write port, flush, and fetch-fault reporting.
//
// state | meaning
// IDLE  | no fetch in flight, ready for a request
// WAIT  | fetch captured, counting down the remaining wait states
// RESP  | response presented, held stable until consumed
module imem_fetch_port #(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned AW          = $clog2(DEPTH),
  parameter logic [31:0] NOP_INSTR   = 32'h00000013
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  logic [31:0]   req_addr_i,
  output logic          resp_valid_o,
  input  logic          resp_ready_i,
  output logic [31:0]   resp_instr_o,
  output logic [31:0]   resp_addr_o,
  output logic          resp_err_o,
  input  logic          flush_i,
  input  logic          prog_we_i,
  input  logic [AW-1:0] prog_addr_i,
  input  logic [31:0]   prog_data_i
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  localparam logic [31:0] DEPTH_W = 32'(DEPTH);
  localparam logic [3:0]  WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam state_e      ACC_STATE = (WAIT_STATES > 0) ? S_WAIT : S_RESP;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q;
  logic [31:0] instr_q;
  logic        err_q;

  logic [31:0] mem_q [DEPTH];

  logic        accept;
  logic        misaligned;
  logic        out_of_range;
  logic        fault;
  logic [31:0] rd_word;

  assign misaligned   = |req_addr_i[1:0];
  assign out_of_range = {2'b00, req_addr_i[31:2]} >= DEPTH_W;
  assign fault        = misaligned | out_of_range;
  assign rd_word      = mem_q[req_addr_i[AW+1:2]];

  // Program-load port is independent of the FSM and of reset; the fetch
  // capture below samples rd_word before this edge's write lands.
  always_ff @(posedge clk_i) begin
    if (prog_we_i) begin
      mem_q[prog_addr_i] <= prog_data_i;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    resp_valid_o = (state_q == S_RESP);
    req_ready_o  = !flush_i &&
                   ((state_q == S_IDLE) || ((state_q == S_RESP) && resp_ready_i));
    accept       = req_valid_i && req_ready_o;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = ACC_STATE;
          cnt_d   = WS_LOAD;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (resp_ready_i) begin
          if (accept) begin
            state_d = ACC_STATE;
            cnt_d   = WS_LOAD;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase

    // A response handshaking in the flush cycle is simply consumed here.
    if (flush_i) begin
      state_d = S_IDLE;
      cnt_d   = 4'd0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      instr_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q  <= req_addr_i;
        err_q   <= fault;
        instr_q <= fault ? NOP_INSTR : rd_word;
      end
    end
  end

  assign resp_instr_o = instr_q;
  assign resp_addr_o  = addr_q;
  assign resp_err_o   = err_q;

endmodule

// File: tb/tb_imem_fetch_port.sv
// Bench for imem_fetch_port: two instances (0 and 3 wait states) checked every
// cycle against a transaction-level model, plus directed literal expectations.
module tb_imem_fetch_port;

  localparam logic [31:0] NOP = 32'h00000013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  rst, req_valid, req_ready, resp_valid, resp_ready, resp_err, flush, prog_we;
  logic [31:0] req_addr [2];
  logic [31:0] resp_instr [2];
  logic [31:0] resp_addr [2];
  logic [31:0] prog_data [2];
  logic [7:0]  prog_addr [2];

  int checks = 0;
  int errors = 0;

  imem_fetch_port #(.DEPTH(256), .WAIT_STATES(0)) u_dut0 (
    .clk_i(clk), .rst_i(rst[0]),
    .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]), .req_addr_i(req_addr[0]),
    .resp_valid_o(resp_valid[0]), .resp_ready_i(resp_ready[0]),
    .resp_instr_o(resp_instr[0]), .resp_addr_o(resp_addr[0]), .resp_err_o(resp_err[0]),
    .flush_i(flush[0]), .prog_we_i(prog_we[0]), .prog_addr_i(prog_addr[0]),
    .prog_data_i(prog_data[0])
  );

  imem_fetch_port #(.DEPTH(256), .WAIT_STATES(3)) u_dut1 (
    .clk_i(clk), .rst_i(rst[1]),
    .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]), .req_addr_i(req_addr[1]),
    .resp_valid_o(resp_valid[1]), .resp_ready_i(resp_ready[1]),
    .resp_instr_o(resp_instr[1]), .resp_addr_o(resp_addr[1]), .resp_err_o(resp_err[1]),
    .flush_i(flush[1]), .prog_we_i(prog_we[1]), .prog_addr_i(prog_addr[1]),
    .prog_data_i(prog_data[1])
  );

  task automatic chk(input string name, input int inst, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %h expected %h at %0t", name, inst, act, exp, $time);
    end
  endtask

  // Model: one pending fetch with the cycle at which it becomes visible.
  bit          m_pend [2];
  bit          m_rst  [2];
  bit          m_err  [2];
  logic [31:0] m_addr [2];
  logic [31:0] m_instr [2];
  int          m_due  [2];
  logic [31:0] m_mem  [2][256];
  int          cyc = 0;
  bit          started = 0;

  function automatic int ws_of(input int i);
    return (i == 0) ? 0 : 3;
  endfunction

  function automatic bit m_vis(input int i);
    return m_pend[i] && (cyc >= m_due[i]);
  endfunction

  function automatic bit m_rdy(input int i);
    return !flush[i] && (!m_pend[i] || (m_vis(i) && resp_ready[i]));
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst[i]) begin
        m_pend[i] = 1'b0;
        m_rst[i]  = 1'b1;
      end else begin
        m_rst[i] = 1'b0;
        if (flush[i]) begin
          m_pend[i] = 1'b0;
        end else if (req_valid[i] && m_rdy(i)) begin
          m_pend[i]  = 1'b1;
          m_addr[i]  = req_addr[i];
          m_err[i]   = (req_addr[i][1:0] != 2'b00) || ((req_addr[i] >> 2) >= 32'd256);
          m_instr[i] = m_err[i] ? NOP : m_mem[i][req_addr[i][9:2]];
          m_due[i]   = cyc + 1 + ws_of(i);
        end else if (m_vis(i) && resp_ready[i]) begin
          m_pend[i] = 1'b0;
        end
      end
      if (prog_we[i]) m_mem[i][prog_addr[i]] = prog_data[i];
    end
    cyc++;
    started = 1'b1;
  end

  always @(negedge clk) begin
    if (started) begin
      for (int i = 0; i < 2; i++) begin
        chk("resp_valid", i, 32'(resp_valid[i]), 32'(m_vis(i)));
        chk("req_ready", i, 32'(req_ready[i]), 32'(m_rdy(i)));
        if (m_vis(i)) begin
          chk("resp_instr", i, resp_instr[i], m_instr[i]);
          chk("resp_addr", i, resp_addr[i], m_addr[i]);
          chk("resp_err", i, 32'(resp_err[i]), 32'(m_err[i]));
        end
        if (m_rst[i]) begin
          chk("rst_instr", i, resp_instr[i], 32'd0);
          chk("rst_addr", i, resp_addr[i], 32'd0);
          chk("rst_err", i, 32'(resp_err[i]), 32'd0);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 2'b11; req_valid = 2'b00; flush = 2'b00; prog_we = 2'b00; resp_ready = 2'b11;
    for (int i = 0; i < 2; i++) begin
      req_addr[i] = 32'd0; prog_addr[i] = 8'd0; prog_data[i] = 32'd0;
    end
    tick(); tick();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("lit_reset_valid", i, 32'(resp_valid[i]), 32'd0);
      chk("lit_reset_instr", i, resp_instr[i], 32'd0);
      chk("lit_reset_ready", i, 32'(req_ready[i]), 32'd1);
    end
    tick();
    rst = 2'b00;

    // fill both memories so every later fetch has a defined word
    prog_we = 2'b11;
    for (int w = 0; w < 256; w++) begin
      for (int i = 0; i < 2; i++) begin
        prog_addr[i] = 8'(w);
        prog_data[i] = $urandom;
      end
      tick();
    end
    prog_we = 2'b00;

    // load and back-to-back fetch, zero wait states
    prog_we[0] = 1'b1; prog_addr[0] = 8'd0; prog_data[0] = 32'h002081B3;
    tick();
    prog_addr[0] = 8'd1; prog_data[0] = 32'h404184B3;
    tick();
    prog_we[0] = 1'b0;
    req_valid[0] = 1'b1; req_addr[0] = 32'h0; resp_ready[0] = 1'b1;
    tick();
    req_addr[0] = 32'h4;
    @(negedge clk);
    chk("lit_b2b_valid0", 0, 32'(resp_valid[0]), 32'd1);
    chk("lit_b2b_instr0", 0, resp_instr[0], 32'h002081B3);
    tick();
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk("lit_b2b_valid1", 0, 32'(resp_valid[0]), 32'd1);
    chk("lit_b2b_instr1", 0, resp_instr[0], 32'h404184B3);
    chk("lit_b2b_err1", 0, 32'(resp_err[0]), 32'd0);
    tick();

    // three wait states
    req_valid[1] = 1'b1; req_addr[1] = 32'h8;
    tick();
    req_valid[1] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("lit_ws_valid_low", 1, 32'(resp_valid[1]), 32'd0);
      chk("lit_ws_ready_low", 1, 32'(req_ready[1]), 32'd0);
      tick();
    end
    @(negedge clk);
    chk("lit_ws_valid_high", 1, 32'(resp_valid[1]), 32'd1);
    chk("lit_ws_addr", 1, resp_addr[1], 32'h8);
    tick();

    // backpressure, then consume and accept in the same cycle
    req_valid[0] = 1'b1; req_addr[0] = 32'h4; resp_ready[0] = 1'b0;
    tick();
    req_addr[0] = 32'h0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("lit_bp_valid", 0, 32'(resp_valid[0]), 32'd1);
      chk("lit_bp_instr", 0, resp_instr[0], 32'h404184B3);
      chk("lit_bp_addr", 0, resp_addr[0], 32'h4);
      chk("lit_bp_ready", 0, 32'(req_ready[0]), 32'd0);
      tick();
    end
    resp_ready[0] = 1'b1;
    @(negedge clk);
    chk("lit_bp_release_ready", 0, 32'(req_ready[0]), 32'd1);
    tick();
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk("lit_bp_next_instr", 0, resp_instr[0], 32'h002081B3);
    chk("lit_bp_next_addr", 0, resp_addr[0], 32'h0);
    tick();

    // faults: misaligned then out of range
    req_valid[0] = 1'b1; req_addr[0] = 32'h6;
    tick();
    req_addr[0] = 32'h400;
    @(negedge clk);
    chk("lit_mis_err", 0, 32'(resp_err[0]), 32'd1);
    chk("lit_mis_instr", 0, resp_instr[0], 32'h00000013);
    chk("lit_mis_addr", 0, resp_addr[0], 32'h6);
    tick();
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk("lit_oor_err", 0, 32'(resp_err[0]), 32'd1);
    chk("lit_oor_instr", 0, resp_instr[0], 32'h00000013);
    chk("lit_oor_addr", 0, resp_addr[0], 32'h400);
    tick();

    // write/read collision on the same word
    prog_we[0] = 1'b1; prog_addr[0] = 8'd2; prog_data[0] = 32'hAAAA0000;
    tick();
    prog_data[0] = 32'hBBBB0000; req_valid[0] = 1'b1; req_addr[0] = 32'h8;
    tick();
    prog_we[0] = 1'b0;
    @(negedge clk);
    chk("lit_coll_old", 0, resp_instr[0], 32'hAAAA0000);
    tick();
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk("lit_coll_new", 0, resp_instr[0], 32'hBBBB0000);
    tick();

    // flush during WAIT
    req_valid[1] = 1'b1; req_addr[1] = 32'hC;
    tick();
    req_valid[1] = 1'b0;
    tick();
    flush[1] = 1'b1;
    @(negedge clk);
    chk("lit_flush_ready", 1, 32'(req_ready[1]), 32'd0);
    tick();
    flush[1] = 1'b0;
    @(negedge clk);
    chk("lit_flush_idle_ready", 1, 32'(req_ready[1]), 32'd1);
    for (int k = 0; k < 4; k++) begin
      tick();
      @(negedge clk);
      chk("lit_flush_no_valid", 1, 32'(resp_valid[1]), 32'd0);
    end

    // reset while a response is held
    tick();
    req_valid[0] = 1'b1; req_addr[0] = 32'h0; resp_ready[0] = 1'b0;
    tick();
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk("lit_rst_pre_valid", 0, 32'(resp_valid[0]), 32'd1);
    tick();
    rst[0] = 1'b1;
    tick();
    rst[0] = 1'b0;
    @(negedge clk);
    chk("lit_rst_valid", 0, 32'(resp_valid[0]), 32'd0);
    chk("lit_rst_instr", 0, resp_instr[0], 32'd0);
    chk("lit_rst_addr", 0, resp_addr[0], 32'd0);
    tick();
    resp_ready[0] = 1'b1; req_valid[0] = 1'b1; req_addr[0] = 32'h0;
    tick();
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk("lit_rst_mem_kept", 0, resp_instr[0], 32'h002081B3);
    tick();

    // randomized traffic on both instances
    repeat (3000) begin
      for (int i = 0; i < 2; i++) begin
        int r;
        rst[i]        = ($urandom_range(0, 99) == 0);
        req_valid[i]  = ($urandom_range(0, 9) < 7);
        resp_ready[i] = ($urandom_range(0, 9) < 7);
        flush[i]      = ($urandom_range(0, 19) == 0);
        prog_we[i]    = ($urandom_range(0, 9) < 3);
        prog_addr[i]  = 8'($urandom_range(0, 15));
        prog_data[i]  = $urandom;
        r = int'($urandom_range(0, 9));
        if (r < 7)       req_addr[i] = {22'd0, 6'($urandom_range(0, 15)), 2'b00};
        else if (r == 7) req_addr[i] = {22'd0, 8'($urandom_range(0, 255)), 2'($urandom_range(1, 3))};
        else             req_addr[i] = $urandom;
      end
      tick();
    end

    rst = 2'b00; req_valid = 2'b00; flush = 2'b00; prog_we = 2'b00; resp_ready = 2'b11;
    repeat (8) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_fetch_port.md
Name: imem_fetch_port

Overview:
- Parametrised instruction memory for the fetch stage. Replaces the combinational ROM with a clocked, handshaked read port.
- Adds configurable depth and read latency (wait states), a program-load write port, flush, and fault reporting for misaligned or out-of-range fetches.
- Sits between the program counter / fetch logic and decode. Allows at most one request in flight.

Parameters:
- DEPTH, 256: number of 32-bit instruction words. Must be a power of 2, ≥ 2.
- WAIT_STATES, 0: extra cycles between request acceptance and response. Range 0..15.
- AW, $clog2(DEPTH): word-index width. Derived; not to be overridden.
- NOP_INSTR, 32'h00000013: instruction returned on a fault (addi x0,x0,0).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  fetch request present.
- req_ready  out  1  request can be accepted this cycle.
- req_addr  in  32  byte address of the fetch.
- resp_valid  out  1  response available.
- resp_ready  in  1  consumer accepts the response.
- resp_instr  out  32  fetched instruction, or NOP_INSTR on a fault.
- resp_addr  out  32  byte address of the returned instruction.
- resp_err  out  1  fault: misaligned (req_addr[1:0]≠0) or out of range (req_addr[31:2] ≥ DEPTH).
- flush  in  1  discard the in-flight or held response.
- prog_we  in  1  program-load write enable.
- prog_addr  in  AW  word index for the program-load write.
- prog_data  in  32  program-load write data.

Behaviour:
- Reset values (rst high at an edge): state=IDLE; resp_valid=0; resp_instr=0; resp_addr=0; resp_err=0; wait counter=0.
  - Memory array is not cleared.
  - Reset overrides everything, including mid-operation requests; any pending response is lost.
- Acceptance occurs when req_valid && req_ready.
  - At acceptance, register req_addr, compute the fault, and read mem[req_addr[AW+1:2]] (read-before-write).
  - Captured data is held until the response is issued.
- req_ready = !flush && (state==IDLE || (state==RESP && resp_ready)). Combinational.
- FSM states:
  - IDLE: on acceptance → WAIT if WAIT_STATES>0 (counter loaded with WAIT_STATES−1), else → RESP.
  - WAIT: counter decrements each cycle; at 0 → RESP.
  - RESP: resp_valid=1; outputs hold stable while !resp_ready.
    - On resp_ready: if a new request is accepted in the same cycle → WAIT or RESP as from IDLE; otherwise → IDLE.
- Latency: a request accepted at edge N gives resp_valid=1 in the cycle after edge N+WAIT_STATES. With WAIT_STATES=0, back-to-back throughput is one fetch per cycle.
- Fault handling: resp_err=1, resp_instr=NOP_INSTR, resp_addr=original address. No memory read effect. Latency is identical to a normal fetch.
  - Misaligned and out-of-range faults are reported identically.
- flush:
  - From any state, the next state is IDLE and resp_valid is 0 the next cycle. req_ready=0 during the flush cycle.
  - A response handshaking in the flush cycle counts as consumed.
- prog_we: writes mem[prog_addr] <= prog_data at the edge. Independent of the FSM, always accepted.
  - Same-cycle write and acceptance to the same word: the fetch returns the OLD word.
  - A write during WAIT/RESP does not alter the already-captured response.
- resp_addr[1:0] passes through unmodified.

Test Plan:
- Load/fetch, WAIT_STATES=0:
  - Stimulus: prog-write mem[0]=32'h002081B3 and mem[1]=32'h404184B3, then request 0x0 and 0x4 back-to-back with resp_ready=1.
  - Required: responses on consecutive cycles, 002081B3 then 404184B3, resp_err=0.
- Wait states, WAIT_STATES=3:
  - Stimulus: request 0x8 accepted at edge N.
  - Required: resp_valid rises after edge N+3; req_ready=0 in between.
- Backpressure:
  - Stimulus: hold resp_ready=0 for 5 cycles with resp_valid=1.
  - Required: resp_instr and resp_addr stable, req_ready=0; on release, the response is consumed and the next request is accepted the same cycle.
- Faults:
  - Stimulus: request 0x6, then 0x400 with DEPTH=256.
  - Required: each gives resp_err=1, resp_instr=00000013, resp_addr=0x6 and 0x400 respectively.
- Write/read collision:
  - Stimulus: mem[2]=AAAA0000; same-cycle prog_we mem[2]=BBBB0000 and fetch 0x8, followed by a second fetch 0x8.
  - Required: first fetch returns AAAA0000, second returns BBBB0000.
- Flush and reset:
  - Flush during WAIT → resp_valid never asserts for that request; IDLE next cycle.
  - rst while in RESP → resp_valid=0 and all outputs 0 next cycle; memory contents retained.
